// File: rtl/dm_access_if.sv
// Request/response bundle between a requester and the data-memory access unit.
// Handshake: a request is taken on a rising edge where req && ready; the requester
// must not rely on req being queued while ready=0. The op's result appears when
// done pulses for one cycle; err qualifies that same cycle, and rdata stays valid
// until the next load completes.
interface dm_access_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W+1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [2:0]        dbg_state;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  ready, done, rdata, err, dbg_state
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output ready, done, rdata, err, dbg_state
  );
endinterface

// File: rtl/dm_access_unit.sv
// Data-memory access unit: DEPTH x 32-bit RAM with byte/halfword/word loads and
// stores; sub-word stores go through a read-merge-write sequence.
module dm_access_unit #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_access_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} state_t;

  state_t            state, state_nx;
  logic              we_q, sx_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rbuf, rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] widx;
  logic [DATA_W-1:0] mem_word, load_val, merged;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              accept, illegal_in;

  assign widx       = addr_q[ADDR_W+1:2];
  assign mem_word   = mem[widx];
  assign accept     = bus.req && (state == IDLE);
  assign illegal_in = (bus.size == 2'b11) ||
                      ((bus.size == 2'b01) && bus.addr[0]) ||
                      ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        if (illegal_in)                          state_nx = RESP;
        else if (bus.we && bus.size == 2'b10)    state_nx = WR;
        else                                     state_nx = RD;
      end
      RD:      state_nx = we_q ? MRG : RESP;
      MRG:     state_nx = WR;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Little-endian lane selection for loads, and lane replacement for sub-word stores.
  always_comb begin
    byte_sel = mem_word[7:0];
    case (addr_q[1:0])
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      2'd3:    byte_sel = mem_word[31:24];
      default: byte_sel = mem_word[7:0];
    endcase
    half_sel = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
    case (size_q)
      2'b00:   load_val = {{(DATA_W-8){sx_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{(DATA_W-16){sx_q & half_sel[15]}}, half_sel};
      default: load_val = mem_word;
    endcase

    merged = rbuf;
    case (size_q)
      2'b00: case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
      2'b01: if (addr_q[1]) merged[31:16] = wdata_q[15:0];
             else           merged[15:0]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      sx_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.we;
        sx_q    <= bus.sign_ext;
        size_q  <= bus.size;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        err_q   <= illegal_in;
      end
      if (state == RD) begin
        rbuf <= mem_word;
        if (!we_q) rdata_q <= load_val;
      end
      if (state == MRG) rbuf <= merged;
    end
  end

  // The write is gated by rst_n so an op aborted in WR leaves the RAM untouched.
  always_ff @(posedge clk) begin
    if (rst_n && state == WR)
      mem[widx] <= (size_q == 2'b10) ? wdata_q : rbuf;
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done      = (state == RESP);
  assign bus.err       = (state == RESP) && err_q;
  assign bus.rdata     = rdata_q;
  assign bus.dbg_state = state;
endmodule
